bin2bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one bit per clock.
- Generalises the fixed 6-bit/2-digit combinational converter to arbitrary BIN_W/DIGITS.
- Adds a start/busy/done handshake and an overflow flag.
- Sits between arithmetic result registers (e.g. divider quotient/remainder) and the 7-segment display driver.

---
 rtl/bin2bcd_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 89 ++++++++
 tb/tb_bin2bcd_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_if.sv
// bin2bcd_if: start/busy/done handshake and result bus of bin2bcd_seq.
// Carries the blank port only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_if #(parameter int BIN_W = 6, parameter int DIGITS = 2);
    logic                  start;
    logic [BIN_W-1:0]      valoare_bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;
`endif
    modport master(output start, valoare_bin, input busy, done, bcd_out, overflow
`ifdef BIN2BCD_BLANK_EN
        , blank
`endif
    );
    modport slave(input start, valoare_bin, output busy, done, bcd_out, overflow
`ifdef BIN2BCD_BLANK_EN
        , blank
`endif
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking output enabled by BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input logic       clk,
    input logic       rst,
    bin2bcd_if.slave  bus
);
    localparam int CW = $clog2(BIN_W + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t              state, state_nx;
    logic [BIN_W-1:0]    sh, sh_nx;
    logic [4*DIGITS-1:0] acc, acc_cor, acc_nx, bcd_q;
    logic [CW-1:0]       cnt;
    logic                carry, ovf_int, busy_q, done_q, ovf_q;
    logic                accept, last;
    assign accept = (state == IDLE) && bus.start;
    assign last   = (state == SHIFT) && (cnt == CW'(1));
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = state;
        if (accept) state_nx = SHIFT;
        else if (last) state_nx = IDLE;
    end
    // Per-digit +3 correction (no inter-digit carry), then a 1-bit left shift of {acc, sh}.
    always_comb begin
        acc_cor = acc;
        for (int k = 0; k < DIGITS; k++)
            acc_cor[4*k +: 4] = (acc[4*k +: 4] > 4'd4) ? acc[4*k +: 4] + 4'd3 : acc[4*k +: 4];
        {carry, acc_nx, sh_nx} = {acc_cor, sh, 1'b0};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            acc     <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                sh      <= bus.valoare_bin;
                acc     <= '0;
                ovf_int <= 1'b0;
                cnt     <= CW'(BIN_W);
                busy_q  <= 1'b1;
            end else if (state == SHIFT) begin
                sh      <= sh_nx;
                acc     <= acc_nx;
                ovf_int <= ovf_int | carry;
                cnt     <= cnt - CW'(1);
                if (last) begin
                    bcd_q  <= acc_nx;
                    ovf_q  <= ovf_int | carry;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            end
        end
    end
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_nx;
    logic              hz;
    // A digit blanks only if it and every digit above it are zero; units never blanks.
    always_comb begin
        blank_nx = '0;
        hz       = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            hz          = hz & (acc_nx[4*k +: 4] == 4'd0);
            blank_nx[k] = hz;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) blank_q <= ~DIGITS'(1);
        else if (last) blank_q <= blank_nx;
    assign bus.blank = blank_q;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized and directed bench for bin2bcd_seq against an arithmetic model.
// Covers (6,2), (8,2), (8,3) and (1,1) configurations; checks blank when BIN2BCD_BLANK_EN is defined.
module tb_bin2bcd_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw  = 1'b0;
    logic [7:0] val8 = 8'd0;
    logic       chk_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    bin2bcd_if #(.BIN_W(6), .DIGITS(2)) ia ();
    bin2bcd_if #(.BIN_W(8), .DIGITS(2)) ib ();
    bin2bcd_if #(.BIN_W(8), .DIGITS(3)) ic ();
    bin2bcd_if #(.BIN_W(1), .DIGITS(1)) id ();

    assign ib.start = sw;
    assign ic.start = sw;
    assign id.start = sw;
    assign ib.valoare_bin = val8;
    assign ic.valoare_bin = val8;
    assign id.valoare_bin = val8[0];

    bin2bcd_seq #(.BIN_W(6), .DIGITS(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_c (.clk(clk), .rst(rst), .bus(ic));
    bin2bcd_seq #(.BIN_W(1), .DIGITS(1)) dut_d (.clk(clk), .rst(rst), .bus(id));

    function automatic int p10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int v, input int d);
        logic [11:0] r = '0;
        for (int k = 0; k < d; k++) r = r | (12'((v / p10(k)) % 10) << (4 * k));
        return r;
    endfunction

    function automatic logic [2:0] blank_of(input int v, input int d);
        logic [2:0] r = '0;
        for (int k = 1; k < d; k++) r[k] = (v / p10(k)) == 0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a conversion is a countdown of W edges, then the decimal digits of v mod 10^D.
    int          mw[4] = '{6, 8, 8, 1};
    int          md[4] = '{2, 2, 3, 1};
    int          m_rem[4], m_v[4];
    logic        m_busy[4], m_done[4], m_ovf[4];
    logic [11:0] m_bcd[4];
    logic [2:0]  m_blank[4];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_rem[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_bcd[i] = '0;
                m_blank[i] = 3'((1 << md[i]) - 2);
            end else begin
                m_done[i] = 0;
                if (m_rem[i] > 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_busy[i]  = 0;
                        m_done[i]  = 1;
                        m_bcd[i]   = to_bcd(m_v[i] % p10(md[i]), md[i]);
                        m_ovf[i]   = m_v[i] >= p10(md[i]);
                        m_blank[i] = blank_of(m_v[i] % p10(md[i]), md[i]);
                    end
                end else if ((i == 0) ? ia.start : sw) begin
                    m_v[i]    = (i == 0) ? int'(ia.valoare_bin) : (int'(val8) & ((1 << mw[i]) - 1));
                    m_rem[i]  = mw[i];
                    m_busy[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        a_busy[4], a_done[4], a_ovf[4];
        logic [11:0] a_bcd[4];
        a_busy = '{ia.busy, ib.busy, ic.busy, id.busy};
        a_done = '{ia.done, ib.done, ic.done, id.done};
        a_ovf  = '{ia.overflow, ib.overflow, ic.overflow, id.overflow};
        a_bcd  = '{12'(ia.bcd_out), 12'(ib.bcd_out), 12'(ic.bcd_out), 12'(id.bcd_out)};
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("busy[%0d]", i), 12'(a_busy[i]), 12'(m_busy[i]));
                chk($sformatf("done[%0d]", i), 12'(a_done[i]), 12'(m_done[i]));
                chk($sformatf("bcd[%0d]", i), a_bcd[i], m_bcd[i]);
                chk($sformatf("ovf[%0d]", i), 12'(a_ovf[i]), 12'(m_ovf[i]));
            end
`ifdef BIN2BCD_BLANK_EN
            chk("blank[0]", 12'(ia.blank), 12'(m_blank[0]));
            chk("blank[1]", 12'(ib.blank), 12'(m_blank[1]));
            chk("blank[2]", 12'(ic.blank), 12'(m_blank[2]));
            chk("blank[3]", 12'(id.blank), 12'(m_blank[3]));
`endif
        end
    end

    task automatic wait_done_a(output bit seen);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ia.done) seen = 1;
        end
    endtask

    task automatic start_a(input logic [5:0] v);
        @(posedge clk); #1 ia.start = 1'b1; ia.valoare_bin = v;
        @(posedge clk); #1 ia.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        int n;
        ia.start = 1'b0;
        ia.valoare_bin = '0;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_bcd", 12'(ia.bcd_out), 12'h000);
        chk("rst_busy", 12'(ia.busy), 12'h000);
        rst = 1'b0;

        // 63: six busy cycles then 8'h63
        start_a(6'd63);
        n = 0; seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ia.done) seen = 1;
            else if (ia.busy) n++;
        end
        chk("done63", 12'(seen), 12'h001);
        chk("busy_len63", 12'(n), 12'd6);
        chk("bcd63", 12'(ia.bcd_out), 12'h063);
        chk("ovf63", 12'(ia.overflow), 12'h000);

        start_a(6'd0);
        wait_done_a(seen);
        chk("done0", 12'(seen), 12'h001);
        chk("bcd0", 12'(ia.bcd_out), 12'h000);
`ifdef BIN2BCD_BLANK_EN
        chk("blank0", 12'(ia.blank), 12'h002);
`endif

        // 45, then a start for 12 while busy must be dropped
        start_a(6'd45);
        @(posedge clk); #1 ia.start = 1'b1; ia.valoare_bin = 6'd12;
        @(posedge clk); #1 ia.start = 1'b0;
        n = 0;
        repeat (14) begin
            @(negedge clk);
            if (ia.done) n++;
        end
        chk("ignored_dones", 12'(n), 12'd1);
        chk("bcd45", 12'(ia.bcd_out), 12'h045);

        // 255 on the 8-bit instances, 1 on the 1-bit instance
        @(posedge clk); #1 sw = 1'b1; val8 = 8'd255;
        @(posedge clk); #1 sw = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ic.done) seen = 1;
        end
        chk("done255", 12'(seen), 12'h001);
        chk("bcd255_d2", 12'(ib.bcd_out), 12'h055);
        chk("ovf255_d2", 12'(ib.overflow), 12'h001);
        chk("bcd255_d3", ic.bcd_out, 12'h255);
        chk("ovf255_d3", 12'(ic.overflow), 12'h000);
        chk("bcd1_w1", 12'(id.bcd_out), 12'h001);

        // reset during the third shift cycle of 37
        start_a(6'd37);
        @(posedge clk);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("abort_busy", 12'(ia.busy), 12'h000);
        chk("abort_bcd", 12'(ia.bcd_out), 12'h000);
        @(negedge clk); rst = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (ia.done) n++;
        end
        chk("abort_nodone", 12'(n), 12'd0);
        start_a(6'd37);
        wait_done_a(seen);
        chk("done37", 12'(seen), 12'h001);
        chk("bcd37", 12'(ia.bcd_out), 12'h037);

        // start held high: 9 then 10 back to back
        @(posedge clk); #1 ia.start = 1'b1; ia.valoare_bin = 6'd9;
        @(posedge clk); #1 ia.valoare_bin = 6'd10;
        wait_done_a(seen);
        chk("done9", 12'(seen), 12'h001);
        chk("bcd9", 12'(ia.bcd_out), 12'h009);
        @(negedge clk);
        chk("handover_busy", 12'(ia.busy), 12'h001);
        @(posedge clk); #1 ia.start = 1'b0;
        wait_done_a(seen);
        chk("done10", 12'(seen), 12'h001);
        chk("bcd10", 12'(ia.bcd_out), 12'h010);

        // random traffic with occasional asynchronous resets
        repeat (900) begin
            @(posedge clk); #1;
            ia.start = ($urandom_range(0, 3) == 0);
            ia.valoare_bin = 6'($urandom);
            sw = ($urandom_range(0, 3) == 0);
            val8 = 8'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        ia.start = 1'b0;
        sw = 1'b0;
        repeat (12) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
